// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_pkg
// Brief    : Shared types and constants for the RV32I instruction fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package ifetch_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] instr_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        instr_t          instr;
    } fetch_entry_t;

    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    // Instruction fetches are always word aligned; the low two bits are dropped.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~(XLEN'(3));
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_fifo
// Brief    : Small register FIFO of {pc, instr} entries with synchronous flush.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  fetch_entry_t                 i_push_data,
    input  logic                         i_pop,
    output fetch_entry_t                 o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int                   c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                   c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0]   c_LAST  = c_PTR_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0]   c_FULL  = c_CNT_W'(DEPTH);

    fetch_entry_t           r_mem [DEPTH];
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_CNT_W-1:0]     r_count;
    logic                   w_do_push;
    logic                   w_do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_LAST) ? '0 : p + c_PTR_W'(1);
    endfunction

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_FULL);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ifetch.sv
`default_nettype none
// ============================================================================
// Module   : ifetch
// Brief    : RV32I fetch stage: PC, credit-limited imem requests, response
//            buffering and redirect flush. IFETCH_ALIGN_CHECK_EN adds misalign.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 4
)(
    input  logic             clk,
    input  logic             reset_n,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [XLEN-1:0]  imem_rdata,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [XLEN-1:0]  instr,
    output logic [XLEN-1:0]  instr_pc,
    input  logic             redirect,
    input  logic [XLEN-1:0]  redirect_pc
`ifdef IFETCH_ALIGN_CHECK_EN
    ,
    output logic             misalign
`endif
);

    localparam int                 c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W:0]   c_LIMIT = (c_CNT_W + 1)'(DEPTH);

    logic [XLEN-1:0]      r_fetch_pc;
    logic [XLEN-1:0]      r_push_pc;
    logic [c_CNT_W-1:0]   r_outstanding;
    logic [c_CNT_W-1:0]   r_drop;
    logic [c_CNT_W-1:0]   w_fifo_count;
    logic [c_CNT_W-1:0]   w_out_after_rsp;
    logic [c_CNT_W:0]     w_inflight;
    logic [XLEN-1:0]      w_target;
    logic                 w_grant;
    logic                 w_discard;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    fetch_entry_t         w_push_entry;
    fetch_entry_t         w_head;

    // Every granted request has a reserved FIFO slot, so the FIFO never overflows.
    assign w_inflight = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
    assign imem_req   = reset_n && !redirect && (w_inflight < c_LIMIT);
    assign imem_addr  = r_fetch_pc;
    assign w_grant    = imem_req && imem_gnt;
    assign w_target   = word_align(redirect_pc);

    assign w_out_after_rsp = imem_rvalid ? (r_outstanding - c_CNT_W'(1)) : r_outstanding;

    // Responses belonging to requests issued before a redirect are stale.
    assign w_discard  = redirect || (r_drop != '0);
    assign w_push     = imem_rvalid && !w_discard && !w_fifo_full;
    assign w_pop      = instr_valid && instr_ready;

    assign w_push_entry.pc    = r_push_pc;
    assign w_push_entry.instr = imem_rdata;

    assign instr_valid = !w_fifo_empty;
    assign instr       = w_head.instr;
    assign instr_pc    = w_head.pc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_pc    <= RESET_PC;
            r_push_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            r_outstanding <= w_grant ? (w_out_after_rsp + c_CNT_W'(1)) : w_out_after_rsp;
            if (redirect) begin
                r_fetch_pc <= w_target;
                r_push_pc  <= w_target;
                r_drop     <= w_out_after_rsp;
            end else begin
                if (w_grant) begin
                    r_fetch_pc <= r_fetch_pc + PC_STEP;
                end
                if (w_push) begin
                    r_push_pc <= r_push_pc + PC_STEP;
                end
                if (imem_rvalid && (r_drop != '0)) begin
                    r_drop <= r_drop - c_CNT_W'(1);
                end
            end
        end
    end

`ifdef IFETCH_ALIGN_CHECK_EN
    logic r_misalign;

    // Sticky until reset or the next redirect that is word aligned.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_misalign <= 1'b0;
        end else if (redirect) begin
            r_misalign <= (redirect_pc[1:0] != 2'b00);
        end
    end

    assign misalign = r_misalign;
`endif

    ifetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_flush     (redirect),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_fifo_count),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_ifetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch
// Brief    : Randomised scoreboard bench for ifetch with a stream-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch;
    import ifetch_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
`ifdef IFETCH_ALIGN_CHECK_EN
    logic        misalign;
    logic        model_mis;
`endif

    always #5 clk = ~clk;

    ifetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
`ifdef IFETCH_ALIGN_CHECK_EN
        ,
        .misalign    (misalign)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_grants = 0;
    int n_hs = 0;
    int first_valid_cyc = -1;

    int gnt_pct = 100, lat_min = 1, lat_max = 1, rdy_pct = 100, redir_pct = 0;
    logic        force_redir = 1'b0;
    logic [31:0] force_target = '0;

    logic [31:0]  mq_addr[$];
    int           mq_due[$];
    fetch_entry_t exp_q[$];
    logic [31:0]  model_pc;
    logic         pend_redir = 1'b0;
    logic [31:0]  pend_target = '0;
    logic         prev_stall = 1'b0;
    logic [31:0]  prev_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1F2E};
    endfunction

    // Monitor: compares each decode handshake against the expected stream.
    initial begin
        fetch_entry_t e;
        forever begin
            @(negedge clk);
            #2;
            if (reset_n === 1'b1 && instr_valid === 1'b1) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (instr_ready === 1'b1) begin
                    n_hs++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_instr: got pc %08h instr %08h, expected none", instr_pc, instr);
                    end else begin
                        e = exp_q.pop_front();
                        check("instr_pc", instr_pc, e.pc);
                        check("instr", instr, e.instr);
                    end
                end
            end
        end
    end

    // One cycle of stimulus, memory model and reference stream, from a negedge.
    task automatic cycle_body();
        logic        redir;
        logic [31:0] tgt;
        int          due;
        imem_gnt = ($urandom_range(99) < gnt_pct);
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mq_addr[0]);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        instr_ready = ($urandom_range(99) < rdy_pct);
        redir       = force_redir || ($urandom_range(99) < redir_pct);
        tgt         = force_redir ? force_target : $urandom;
        force_redir = 1'b0;
        redirect    = redir;
        redirect_pc = redir ? tgt : $urandom;
        #1;
        if (pend_redir) begin
            check("redir_valid_low", instr_valid, 0);
            check("redir_addr", imem_addr, pend_target);
            check("redir_req", imem_req, (!redir && mq_addr.size() < DEPTH) ? 1 : 0);
`ifdef IFETCH_ALIGN_CHECK_EN
            check("misalign", misalign, model_mis);
`endif
            pend_redir = 1'b0;
        end
        if (redir) check("req_in_redirect", imem_req, 0);
        if (prev_stall && !redir) begin
            check("stall_req", imem_req, 1);
            check("stall_addr", imem_addr, prev_addr);
        end
        prev_stall = imem_req && !imem_gnt;
        prev_addr  = imem_addr;
        if (imem_rvalid) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (imem_req && imem_gnt) begin
            fetch_entry_t e;
            check("fetch_addr", imem_addr, model_pc);
            e.pc    = model_pc;
            e.instr = mem_word(model_pc);
            exp_q.push_back(e);
            model_pc = model_pc + 32'd4;
            due = cyc + $urandom_range(lat_max, lat_min);
            mq_addr.push_back(imem_addr);
            mq_due.push_back(due);
            n_grants++;
        end
        #2;
        if (redir) begin
            exp_q.delete();
            model_pc    = {tgt[31:2], 2'b00};
            pend_redir  = 1'b1;
            pend_target = {tgt[31:2], 2'b00};
`ifdef IFETCH_ALIGN_CHECK_EN
            model_mis   = (tgt[1:0] != 2'b00);
`endif
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        cycle_body();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic redirect_to(input logic [31:0] t);
        force_redir  = 1'b1;
        force_target = t;
        step();
    endtask

    initial begin
        int g0, h0;
        reset_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        model_pc = RESET_PC;
`ifdef IFETCH_ALIGN_CHECK_EN
        model_mis = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_instr_pc", instr_pc, 0);
`ifdef IFETCH_ALIGN_CHECK_EN
        check("rst_misalign", misalign, 0);
`endif
        // Release at a negedge; this half-cycle is cycle 0.
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("req_after_release", imem_req, 1);
        cycle_body();

        // Back-to-back streaming and sustained throughput.
        run(9);
        check("first_valid_cycle", first_valid_cyc, 2);
        h0 = n_hs;
        run(20);
        check("throughput", n_hs - h0, 20);

        // Drain, then stall decode: credits cap grants at DEPTH.
        gnt_pct = 0; run(8);
        gnt_pct = 100; rdy_pct = 0;
        g0 = n_grants;
        run(10);
        check("grants_while_stalled", n_grants - g0, DEPTH);
        check("req_low_when_full", imem_req, 0);
        rdy_pct = 100; run(12);

        // Two requests in flight at latency 3, then redirect.
        gnt_pct = 0; run(6);
        gnt_pct = 100; lat_min = 3; lat_max = 3;
        run(2);
        redirect_to(32'h0000_0100);
        run(15);

        // Grant stall: address must hold.
        lat_min = 1; lat_max = 1;
        gnt_pct = 0; run(5);
        gnt_pct = 100; run(8);

        // Address wrap at the top of the space.
        redirect_to(32'hFFFF_FFF8);
        run(10);

        // Misaligned redirect truncates; a later aligned one clears the flag.
        redirect_to(32'h0000_0102);
        run(6);
        redirect_to(32'h0000_0200);
        run(6);

        // Random traffic.
        gnt_pct = 70; lat_min = 1; lat_max = 4; rdy_pct = 60; redir_pct = 3;
        run(1500);

        // Drain and confirm nothing is left over.
        redir_pct = 0; gnt_pct = 0; rdy_pct = 100;
        run(25);
        check("drain_exp_empty", exp_q.size(), 0);
        check("drain_mem_empty", mq_addr.size(), 0);
        check("drain_valid_low", instr_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
